// File: rtl/ice_poll_pkg.sv
// Shared types and default parameter values for the ICE motor poll scheduler.
package ice_poll_pkg;

  localparam int DEF_NUMBER_OF_MOTORS = 8;
  localparam int DEF_CLOCK_FREQ_HZ    = 50_000_000;
  localparam int DEF_TIMEOUT_CYCLES   = 5000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    NEXT   = 3'd4
  } poll_state_t;

  typedef enum logic {
    REQ_STATUS = 1'b0,
    REQ_CONFIG = 1'b1
  } req_type_t;

endpackage

// File: rtl/ice_rate_tick.sv
// Phase-accumulator rate generator: one tick per CLOCK_FREQ_HZ/freq cycles on average.
module ice_rate_tick
  import ice_poll_pkg::*;
#(
  parameter int CLOCK_FREQ_HZ = DEF_CLOCK_FREQ_HZ
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] freq,
  output logic        tick
);

  localparam logic [32:0] CLK_HZ = 33'(CLOCK_FREQ_HZ);

  logic [31:0] r_acc;
  logic        r_tick;
  logic [32:0] w_sum;

  // One extra bit so the sum cannot wrap before the compare.
  assign w_sum = {1'b0, r_acc} + {1'b0, freq};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc  <= '0;
      r_tick <= 1'b0;
    end else if (freq == 32'd0) begin
      r_tick <= 1'b0;
    end else if (w_sum >= CLK_HZ) begin
      r_acc  <= 32'(w_sum - CLK_HZ);
      r_tick <= 1'b1;
    end else begin
      r_acc  <= w_sum[31:0];
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/ice_poll_scheduler.sv
// Round-robin status/config poll scheduler for the motor coms engine.
// Optional per-motor timeout counters are built when POLL_TIMEOUT_STATS_EN is defined.
module ice_poll_scheduler
  import ice_poll_pkg::*;
#(
  parameter int NUMBER_OF_MOTORS = DEF_NUMBER_OF_MOTORS,
  parameter int CLOCK_FREQ_HZ    = DEF_CLOCK_FREQ_HZ,
  parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [31:0]                   update_frequency_Hz,
  input  logic [NUMBER_OF_MOTORS-1:0]   motor_enable,
  input  logic [NUMBER_OF_MOTORS-1:0]   cfg_dirty,
  output logic                          req_valid,
  input  logic                          req_ready,
  output logic [7:0]                    req_motor,
  output logic                          req_type,
  input  logic                          resp_done,
  input  logic                          resp_crc_ok,
  output logic                          busy,
  output logic                          round_done,
  output logic                          overrun,
  output logic                          timeout,
`ifdef POLL_TIMEOUT_STATS_EN
  output logic [NUMBER_OF_MOTORS*16-1:0] timeout_count,
`endif
  output poll_state_t                   o_dbg_state,
  output logic [NUMBER_OF_MOTORS-1:0]   o_dbg_pending
);

  // Handshake: a request transfers on the cycle req_valid && req_ready; req_motor and
  // req_type are held from the first cycle of req_valid until that transfer.

  localparam logic [7:0]                  LAST_IDX = 8'(NUMBER_OF_MOTORS);
  localparam logic [31:0]                 TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [NUMBER_OF_MOTORS-1:0] ONE      = (NUMBER_OF_MOTORS)'(1);

  poll_state_t                 r_state, w_state_nxt;
  logic [7:0]                  r_index;
  logic [31:0]                 r_wait_cnt;
  logic [NUMBER_OF_MOTORS-1:0] r_pending;
  logic [7:0]                  r_req_motor;
  req_type_t                   r_req_type;
  logic                        r_round_done, r_overrun, r_timeout;

  logic                        w_tick, w_sel_end, w_sel_en, w_sel_pend;
  logic                        w_accept, w_resp, w_tmo, w_fail;
  logic [NUMBER_OF_MOTORS-1:0] w_sel_mask, w_req_mask, w_pend_set, w_pend_clr;

  ice_rate_tick #(.CLOCK_FREQ_HZ(CLOCK_FREQ_HZ)) u_rate_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .freq    (update_frequency_Hz),
    .tick    (w_tick)
  );

  assign w_sel_mask = ONE << r_index;
  assign w_req_mask = ONE << r_req_motor;
  assign w_sel_end  = (r_index >= LAST_IDX);
  assign w_sel_en   = |(motor_enable & w_sel_mask);
  assign w_sel_pend = |(r_pending & w_sel_mask);
  assign w_accept   = (r_state == ISSUE) && req_ready;
  assign w_resp     = (r_state == WAIT) && resp_done;
  // A response in the final counted cycle beats the timeout.
  assign w_tmo      = (r_state == WAIT) && !resp_done && (r_wait_cnt == TMO_LAST);
  assign w_fail     = (r_req_type == REQ_CONFIG) && (w_tmo || (w_resp && !resp_crc_ok));
  assign w_pend_clr = (w_accept && (r_req_type == REQ_CONFIG)) ? w_req_mask : '0;
  assign w_pend_set = cfg_dirty | (w_fail ? w_req_mask : '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_tick) w_state_nxt = SELECT;
      SELECT:  if (w_sel_end) w_state_nxt = IDLE;
               else if (w_sel_en) w_state_nxt = ISSUE;
      ISSUE:   if (req_ready) w_state_nxt = WAIT;
      WAIT:    if (resp_done || w_tmo) w_state_nxt = NEXT;
      NEXT:    w_state_nxt = SELECT;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_index      <= '0;
      r_wait_cnt   <= '0;
      r_pending    <= '0;
      r_req_motor  <= '0;
      r_req_type   <= REQ_STATUS;
      r_round_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pending    <= (r_pending & ~w_pend_clr) | w_pend_set;
      r_round_done <= (r_state == SELECT) && w_sel_end;
      r_overrun    <= w_tick && (r_state != IDLE);
      r_timeout    <= w_tmo;
      r_wait_cnt   <= (r_state == WAIT) ? r_wait_cnt + 32'd1 : '0;
      if (r_state == IDLE && w_tick) r_index <= '0;
      if (r_state == NEXT) r_index <= r_index + 8'd1;
      if (r_state == SELECT && !w_sel_end) begin
        if (w_sel_en) begin
          r_req_motor <= r_index;
          r_req_type  <= w_sel_pend ? REQ_CONFIG : REQ_STATUS;
        end else begin
          r_index <= r_index + 8'd1;
        end
      end
    end
  end

`ifdef POLL_TIMEOUT_STATS_EN
  logic [NUMBER_OF_MOTORS*16-1:0] r_tmo_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tmo_cnt <= '0;
    end else begin
      for (int i = 0; i < NUMBER_OF_MOTORS; i++) begin
        if (w_tmo && r_req_motor == 8'(i) && r_tmo_cnt[i*16 +: 16] != 16'hFFFF)
          r_tmo_cnt[i*16 +: 16] <= r_tmo_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end

  assign timeout_count = r_tmo_cnt;
`endif

  assign req_valid     = (r_state == ISSUE);
  assign req_motor     = r_req_motor;
  assign req_type      = r_req_type;
  assign busy          = (r_state != IDLE);
  assign round_done    = r_round_done;
  assign overrun       = r_overrun;
  assign timeout       = r_timeout;
  assign o_dbg_state   = r_state;
  assign o_dbg_pending = r_pending;

endmodule

// File: tb/tb_ice_poll_scheduler.sv
// Bench for ice_poll_scheduler: tick-rate table, random rate model, and poll rounds
// scored against a request-order model of the pending/enable rules.
module tb_ice_poll_scheduler;
  import ice_poll_pkg::*;

  localparam int N      = 8;
  localparam int CLK_HZ = 50_000_000;
  localparam int TMO    = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] update_frequency_Hz = '0;
  logic [N-1:0] motor_enable = '0;
  logic [N-1:0] cfg_dirty = '0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [7:0]  req_motor;
  logic        req_type;
  logic        resp_done = 1'b0;
  logic        resp_crc_ok = 1'b0;
  logic        busy, round_done, overrun, timeout;
  poll_state_t dbg_state;
  logic [N-1:0] dbg_pending;
`ifdef POLL_TIMEOUT_STATS_EN
  logic [N*16-1:0] timeout_count;
`endif

  ice_poll_scheduler #(
    .NUMBER_OF_MOTORS (N),
    .CLOCK_FREQ_HZ    (CLK_HZ),
    .TIMEOUT_CYCLES   (TMO)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .update_frequency_Hz (update_frequency_Hz),
    .motor_enable        (motor_enable),
    .cfg_dirty           (cfg_dirty),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_motor           (req_motor),
    .req_type            (req_type),
    .resp_done           (resp_done),
    .resp_crc_ok         (resp_crc_ok),
    .busy                (busy),
    .round_done          (round_done),
    .overrun             (overrun),
    .timeout             (timeout),
`ifdef POLL_TIMEOUT_STATS_EN
    .timeout_count       (timeout_count),
`endif
    .o_dbg_state         (dbg_state),
    .o_dbg_pending       (dbg_pending)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0, rd_cnt = 0, ovr_cnt = 0, tmo_g = 0;
  int rd_times[$];

  always @(negedge clk) begin
    cyc++;
    if (round_done) begin rd_cnt++; rd_times.push_back(cyc); end
    if (overrun) ovr_cnt++;
    if (timeout) tmo_g++;
  end

  // ---------------- scoreboard / model state ----------------
  logic [8:0]   exp_q[$];
  logic [N-1:0] pend_m;
  int           tmo_m[N];
  int           plan_ready[N];
  int           plan_delay[N];   // 0 = never respond
  bit           plan_crc[N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    update_frequency_Hz = '0; cfg_dirty = '0; req_ready = 1'b0; resp_done = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    pend_m = '0;
    for (int i = 0; i < N; i++) tmo_m[i] = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic fire_tick();
    @(negedge clk); update_frequency_Hz = CLK_HZ;
    @(negedge clk); update_frequency_Hz = '0;
  endtask

  task automatic pulse_dirty(input logic [N-1:0] m);
    @(negedge clk); cfg_dirty = m;
    @(negedge clk); cfg_dirty = '0;
    pend_m |= m;
  endtask

  task automatic set_plan(input int rdy, input int dly, input bit crc);
    for (int i = 0; i < N; i++) begin plan_ready[i] = rdy; plan_delay[i] = dly; plan_crc[i] = crc; end
  endtask

  task automatic rand_plan();
    for (int i = 0; i < N; i++) begin
      int r;
      r = $urandom_range(0, 9);
      plan_ready[i] = $urandom_range(0, 2);
      plan_delay[i] = (r == 0) ? 0 : (r == 1) ? 16 : $urandom_range(1, 5);
      plan_crc[i]   = ($urandom_range(0, 3) != 0);
    end
  endtask

  // One tick, then act as the coms engine until round_done; compare against the model.
  task automatic do_round(input logic [N-1:0] en);
    int phase, cnt, cur, ci, tmo_seen, tmo_exp, rd0;
    bit done;
    motor_enable = en;
    tmo_exp = 0;
    for (int i = 0; i < N; i++) begin
      if (en[i]) begin
        exp_q.push_back({8'(i), pend_m[i]});
        if (pend_m[i]) pend_m[i] = (plan_delay[i] == 0) || !plan_crc[i];
        if (plan_delay[i] == 0) begin tmo_exp++; tmo_m[i]++; end
      end
    end
    rd0 = rd_cnt;
    fire_tick();
    phase = 0; cnt = 0; cur = 0; ci = 0; tmo_seen = 0; done = 0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk);
      req_ready = 1'b0; resp_done = 1'b0; resp_crc_ok = 1'b0;
      if (round_done) done = 1;
      if (phase == 0 && req_valid) begin
        cur = int'(req_motor); ci = cur % N; cnt = 0; phase = 1;
        if (exp_q.size() == 0) fail_now($sformatf("req_unexpected motor=%0d", cur));
        else check("req_motor_type", {req_motor, req_type}, exp_q.pop_front());
      end
      if (phase == 1) begin
        if (cnt > 0) check("req_hold", {req_valid, req_motor}, {1'b1, 8'(cur)});
        if (cnt == plan_ready[ci]) begin req_ready = 1'b1; phase = 2; cnt = 0; end
        else cnt++;
      end else if (phase == 2) begin
        cnt++;
        check("valid_low_in_wait", req_valid, 0);
        if (timeout) begin
          tmo_seen++;
          check("timeout_latency", cnt, TMO + 1);
          check("timeout_planned", plan_delay[ci], 0);
          phase = 0;
        end else if (plan_delay[ci] != 0 && cnt == plan_delay[ci]) begin
          resp_done = 1'b1; resp_crc_ok = plan_crc[ci]; phase = 0;
        end else if (cnt > TMO + 4) begin
          fail_now("timeout_missing");
          phase = 0;
        end
      end
    end
    if (!done) fail_now("round_bound");
    check("round_reqs_left", exp_q.size(), 0);
    exp_q.delete();
    check("round_timeouts", tmo_seen, tmo_exp);
    repeat (3) @(negedge clk);
    check("busy_after_round", busy, 0);
    check("round_done_once", rd_cnt - rd0, 1);
    check("pending_bits", dbg_pending, pend_m);
`ifdef POLL_TIMEOUT_STATS_EN
    for (int i = 0; i < N; i++) check($sformatf("timeout_count[%0d]", i), timeout_count[i*16 +: 16], tmo_m[i]);
`endif
  endtask

  // ---------------- tick-rate table ----------------
  typedef struct {
    logic [31:0] freq;
    int          cycles;
    int          exp_ticks;
    int          exp_gap;    // 0 = spacing not checked
  } tick_vec_t;

  tick_vec_t tv[7];

  task automatic run_rate(input logic [31:0] f, input int n, output int ticks);
    int rd0, ov0;
    do_reset();
    motor_enable = '0;
    rd0 = rd_cnt; ov0 = ovr_cnt;
    rd_times.delete();
    @(negedge clk); update_frequency_Hz = f;
    repeat (n) @(posedge clk);
    @(negedge clk); update_frequency_Hz = '0;
    repeat (20) @(negedge clk);
    ticks = (rd_cnt - rd0) + (ovr_cnt - ov0);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks, tmo0, rd0;
    longint exp_t;
    logic [31:0] f;
    int n;

    tv[0] = '{32'd1_000_000,  500, 10, 50};
    tv[1] = '{32'd0,          300,  0,  0};
    tv[2] = '{32'd50_000_000,  20, 20,  0};
    tv[3] = '{32'd25_000_000,  40, 20,  0};
    tv[4] = '{32'd3_000_000,  100,  6,  0};
    tv[5] = '{32'd12_345_678,  81, 19,  0};
    tv[6] = '{32'd2_000_000,  200,  8, 25};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_outputs", {req_valid, req_motor, req_type, busy, round_done, overrun, timeout}, 0);
    check("rst_state", dbg_state, IDLE);
    check("rst_pending", dbg_pending, 0);
    do_reset();

    // Table-driven tick rates
    for (int r = 0; r < 7; r++) begin
      run_rate(tv[r].freq, tv[r].cycles, ticks);
      check($sformatf("tick_count[%0d]", r), ticks, tv[r].exp_ticks);
      if (tv[r].exp_gap != 0)
        for (int k = 1; k < rd_times.size(); k++)
          check($sformatf("tick_gap[%0d.%0d]", r, k), rd_times[k] - rd_times[k-1], tv[r].exp_gap);
    end

    // Random rates against floor(cycles * f / clk)
    for (int r = 0; r < 4; r++) begin
      f = $urandom_range(0, 8_000_000);
      n = $urandom_range(50, 400);
      exp_t = (longint'(n) * longint'(f)) / CLK_HZ;
      run_rate(f, n, ticks);
      check($sformatf("rand_ticks f=%0d n=%0d", f, n), ticks, exp_t);
    end

    do_reset();
    // resp_done while idle has no effect
    @(negedge clk); resp_done = 1'b1; resp_crc_ok = 1'b0;
    @(negedge clk); resp_done = 1'b0;
    @(negedge clk);
    check("idle_resp_ignored", {busy, dbg_pending}, 0);

    // All motors, 3-cycle responses: 0..7 in order, one round_done
    set_plan(0, 3, 1'b1);
    do_round(8'hFF);

    // Motor 0 status then motor 2 config; pending bit 2 clears
    pulse_dirty(8'h04);
    set_plan(1, 3, 1'b1);
    do_round(8'b0000_0101);
    check("pend2_cleared", dbg_pending[2], 0);

    // Timeout on motor 1 (config, stays pending), enable dropped mid-wait;
    // motor 2 config answered in the last counted cycle with bad CRC.
    pulse_dirty(8'h06);
    set_plan(0, 3, 1'b1);
    plan_delay[1] = 0;
    plan_delay[2] = TMO; plan_crc[2] = 1'b0;
    fork
      do_round(8'b0000_0110);
      begin
        for (int k = 0; k < 200 && dbg_state != WAIT; k++) @(negedge clk);
        motor_enable = 8'b0000_0100;
      end
    join
    check("pend_after_fail", dbg_pending[2:1], 2'b11);
    set_plan(0, 2, 1'b1);
    do_round(8'b0000_0110);

    // Second tick during a busy round
    begin
      int ov0;
      ov0 = ovr_cnt;
      set_plan(1, 4, 1'b1);
      fork
        do_round(8'hFF);
        begin repeat (14) @(negedge clk); fire_tick(); end
      join
      check("overrun_pulses", ovr_cnt - ov0, 1);
    end

    // Reset during WAIT
    pulse_dirty(8'h0A);
    motor_enable = 8'hFF;
    fire_tick();
    for (int k = 0; k < 60 && !req_valid; k++) @(negedge clk);
    if (!req_valid) fail_now("rst_test_no_req");
    req_ready = 1'b1;
    @(negedge clk); req_ready = 1'b0;
    check("rst_test_in_wait", dbg_state, WAIT);
    tmo0 = tmo_g; rd0 = rd_cnt;
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_outputs", {req_valid, req_motor, req_type, busy, round_done, overrun, timeout}, 0);
    check("midrst_state", dbg_state, IDLE);
    check("midrst_pending", dbg_pending, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    pend_m = '0;
    for (int i = 0; i < N; i++) tmo_m[i] = 0;
    repeat (TMO + 8) @(negedge clk);
    check("midrst_no_pulses", {tmo_g - tmo0, rd_cnt - rd0}, 0);
    check("midrst_outputs_after", {req_valid, req_motor, req_type, busy, round_done, overrun, timeout}, 0);
    set_plan(0, 2, 1'b1);
    do_round(8'hFF);

    // Random rounds
    for (int r = 0; r < 6; r++) begin
      pulse_dirty(N'($urandom_range(0, 255)));
      rand_plan();
      do_round(N'($urandom_range(1, 255)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
